stack_based_alu: RTL and testbench

Signed integer ALU built around an internal LIFO stack. Operands are pushed from a data port; add and multiply act on the two topmost entries, and pop returns the top entry. The block is a self-contained datapath leaf driven by a single opcode per clock. It reports signed overflow for arithmetic results.

---
 rtl/stack_based_alu.sv | 112 +++++++++++
 tb/tb_stack_based_alu.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/stack_based_alu.sv
// rtl/stack_based_alu.sv - signed LIFO-stack ALU (push/pop/add/multiply) with overflow flag.
// Optional macro STACK_ALU_SAT_EN: saturate add/multiply results on signed overflow.
module stack_based_alu #(
    parameter int n     = 8,
    parameter int DEPTH = 8
) (
    input  logic         CLK,
    input  logic [n-1:0] input_data,
    input  logic [2:0]   opcode,
    output logic [n-1:0] output_data,
    output logic         overflow,
    input  logic         RST
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [n-1:0] SAT_MAX = {1'b0, {(n-1){1'b1}}};
    localparam logic [n-1:0] SAT_MIN = {1'b1, {(n-1){1'b0}}};

    logic [n-1:0]      mem [DEPTH];
    logic [CW-1:0]     count;
    logic [AW-1:0]     push_idx;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     second_idx;
    logic [n-1:0]      top;
    logic [n-1:0]      second;
    logic [n:0]        sum;
    logic signed [2*n-1:0] prod;
    logic              add_ovf;
    logic              mul_ovf;
    logic [n-1:0]      add_res;
    logic [n-1:0]      mul_res;
    logic              is_full;
    logic              is_empty;
    logic              has_two;

    // Index values are only used when count guarantees they are in range.
    assign push_idx   = AW'(count);
    assign top_idx    = AW'(count - CW'(1));
    assign second_idx = AW'(count - CW'(2));
    assign top        = mem[top_idx];
    assign second     = mem[second_idx];

    assign is_full  = (count == CW'(DEPTH));
    assign is_empty = (count == '0);
    assign has_two  = (count >= CW'(2));

    // One extra bit holds the exact sum; 2n bits hold the exact product.
    assign sum     = {top[n-1], top} + {second[n-1], second};
    assign prod    = $signed({{n{top[n-1]}}, top}) * $signed({{n{second[n-1]}}, second});
    assign add_ovf = (sum[n] != sum[n-1]);
    assign mul_ovf = (prod[2*n-1:n-1] != {(n+1){prod[n-1]}});

`ifdef STACK_ALU_SAT_EN
    assign add_res = add_ovf ? (sum[n] ? SAT_MIN : SAT_MAX) : sum[n-1:0];
    assign mul_res = mul_ovf ? (prod[2*n-1] ? SAT_MIN : SAT_MAX) : prod[n-1:0];
`else
    assign add_res = sum[n-1:0];
    assign mul_res = prod[n-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            count       <= '0;
            output_data <= '0;
            overflow    <= 1'b0;
        end else begin
            case (opcode)
                OP_ADD: begin
                    if (has_two) begin
                        output_data <= add_res;
                        overflow    <= add_ovf;
                    end
                end
                OP_MUL: begin
                    if (has_two) begin
                        output_data <= mul_res;
                        overflow    <= mul_ovf;
                    end
                end
                OP_PUSH: begin
                    if (!is_full) begin
                        count    <= count + CW'(1);
                        overflow <= 1'b0;
                    end
                end
                OP_POP: begin
                    if (!is_empty) begin
                        count       <= count - CW'(1);
                        output_data <= top;
                        overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage needs no reset: a zero count makes every entry unreachable.
    always_ff @(posedge CLK) begin
        if (!RST && opcode == OP_PUSH && !is_full) begin
            mem[push_idx] <= input_data;
        end
    end

endmodule

// File: tb/tb_stack_based_alu.sv
// tb/tb_stack_based_alu.sv - randomized self-checking bench for stack_based_alu against a queue model.
module tb_stack_based_alu;

    localparam int N     = 8;
    localparam int DEPTH = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] input_data = '0;
    logic [2:0]   opcode = 3'b000;
    logic [N-1:0] output_data;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    int           stk[$];
    logic [N-1:0] exp_out = '0;
    logic         exp_ovf = 1'b0;

    stack_based_alu #(.n(N), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .input_data(input_data),
        .opcode(opcode),
        .output_data(output_data),
        .overflow(overflow),
        .RST(RST)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    function automatic void arith(input int r);
        logic [31:0] rv;
        rv = r;
        exp_ovf = (r > 127) || (r < -128);
`ifdef STACK_ALU_SAT_EN
        if (r > 127)       exp_out = 8'h7F;
        else if (r < -128) exp_out = 8'h80;
        else               exp_out = rv[7:0];
`else
        exp_out = rv[7:0];
`endif
    endfunction

    function automatic void model(input logic rst, input logic [2:0] op, input logic [N-1:0] d);
        int v;
        if (rst) begin
            stk.delete();
            exp_out = '0;
            exp_ovf = 1'b0;
        end else begin
            case (op)
                3'b100: if (stk.size() >= 2) arith(stk[$] + stk[$-1]);
                3'b101: if (stk.size() >= 2) arith(stk[$] * stk[$-1]);
                3'b110: if (stk.size() < DEPTH) begin
                    v = $signed(d);
                    stk.push_back(v);
                    exp_ovf = 1'b0;
                end
                3'b111: if (stk.size() > 0) begin
                    v = stk.pop_back();
                    exp_out = v[7:0];
                    exp_ovf = 1'b0;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic step(input string tag, input logic rst, input logic [2:0] op, input logic [N-1:0] d);
        @(negedge CLK);
        RST        = rst;
        opcode     = op;
        input_data = d;
        @(posedge CLK);
        #1;
        model(rst, op, d);
        check({tag, ".out"}, {24'b0, output_data}, {24'b0, exp_out});
        check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
    endtask

    task automatic push(input string tag, input int v);
        logic [31:0] w;
        w = v;
        step(tag, 1'b0, 3'b110, w[7:0]);
    endtask

    int plan_vals[6] = '{14, 7, -4, -6, -125, -2};

    initial begin
        // reset with a push pending: reset must win
        step("rst", 1'b1, 3'b110, 8'h55);
        for (int i = 0; i < 3; i++) step("nop", 1'b0, 3'b000, 8'($urandom));

        for (int i = 0; i < 3; i++) push("rstpush", i + 20);
        step("rstmid", 1'b1, 3'b000, 8'h00);
        step("pop_after_rst", 1'b0, 3'b111, 8'h00);
        check("pop_after_rst.lit", {24'b0, output_data}, 32'd0);

        foreach (plan_vals[i]) push("plan_push", plan_vals[i]);
        step("plan_add", 1'b0, 3'b100, 8'h00);
        check("plan_add.lit", {24'b0, output_data}, 32'h81);
        step("plan_mul", 1'b0, 3'b101, 8'h00);
`ifdef STACK_ALU_SAT_EN
        check("plan_mul.lit", {24'b0, output_data}, 32'h7F);
`else
        check("plan_mul.lit", {24'b0, output_data}, 32'hFA);
`endif
        check("plan_mul.ovf_lit", {31'b0, overflow}, 32'd1);
        step("plan_pop", 1'b0, 3'b111, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step("plan_add2", 1'b0, 3'b100, 8'h00);
            step("plan_mul2", 1'b0, 3'b101, 8'h00);
            step("plan_pop2", 1'b0, 3'b111, 8'h00);
        end
        // one entry (14) left: arithmetic must hold outputs
        step("plan_add1", 1'b0, 3'b100, 8'h00);
        step("plan_mul1", 1'b0, 3'b101, 8'h00);

        step("depth_rst", 1'b1, 3'b000, 8'h00);
        for (int i = 1; i <= DEPTH + 1; i++) push("depth_push", i);
        step("depth_pop_first", 1'b0, 3'b111, 8'h00);
        check("depth_pop_first.lit", {24'b0, output_data}, 32'd8);
        for (int i = 0; i < DEPTH; i++) step("depth_pop", 1'b0, 3'b111, 8'h00);
        check("depth_hold.lit", {24'b0, output_data}, 32'd1);
        push("one_push", 5);
        step("one_add", 1'b0, 3'b100, 8'h00);

        // random ops with occasional resets and extreme operands
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]   op;
            logic [N-1:0] d;
            logic         r;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = 3'b110;
            case ($urandom_range(0, 5))
                0:       d = 8'h80;
                1:       d = 8'h7F;
                2:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            r = ($urandom_range(0, 99) == 0);
            step("rand", r, op, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
